// File: rtl/pipe_control_unit.sv
// RV32I control unit for a five-stage pipeline: decodes in ID, carries control
// through ID/EX, EX/MEM and MEM/WB, resolves branches in EX and drives stall, flush and forwarding.
module pipe_control_unit #(
  parameter int INSTR_WIDTH    = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALUCTRL_WIDTH  = 3,
  parameter int IMMSRC_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [INSTR_WIDTH-1:0]    instr_d_i,
  input  logic                      zero_e_i,
  output logic [IMMSRC_WIDTH-1:0]   imm_src_d_o,
  output logic                      illegal_d_o,
  output logic [ALUCTRL_WIDTH-1:0]  alu_control_e_o,
  output logic                      alu_src_e_o,
  output logic                      pc_src_e_o,
  output logic                      pc_src_reg_e_o,
  output logic [1:0]                forward_a_e_o,
  output logic [1:0]                forward_b_e_o,
  output logic                      mem_write_m_o,
  output logic [1:0]                result_src_w_o,
  output logic                      reg_write_w_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_w_o,
  output logic                      stall_f_o,
  output logic                      stall_d_o,
  output logic                      flush_d_o,
  output logic                      flush_e_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = ALUCTRL_WIDTH'(0);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(1);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = ALUCTRL_WIDTH'(2);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = ALUCTRL_WIDTH'(3);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR = ALUCTRL_WIDTH'(4);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = ALUCTRL_WIDTH'(5);

  localparam logic [IMMSRC_WIDTH-1:0] IMM_I = IMMSRC_WIDTH'(0);
  localparam logic [IMMSRC_WIDTH-1:0] IMM_S = IMMSRC_WIDTH'(1);
  localparam logic [IMMSRC_WIDTH-1:0] IMM_B = IMMSRC_WIDTH'(2);
  localparam logic [IMMSRC_WIDTH-1:0] IMM_J = IMMSRC_WIDTH'(3);
  localparam logic [IMMSRC_WIDTH-1:0] IMM_U = IMMSRC_WIDTH'(4);

  typedef struct packed {
    logic                      reg_write;
    logic [1:0]                result_src;
    logic                      mem_write;
    logic                      branch;
    logic                      branch_ne;
    logic                      jump;
    logic                      jalr;
    logic [ALUCTRL_WIDTH-1:0]  alu_control;
    logic                      alu_src;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } ctrl_t;

  logic [6:0]                opcode;
  logic [2:0]                func3;
  logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, rd_d;
  logic                      unused_instr_bits;

  assign opcode = instr_d_i[6:0];
  assign func3  = instr_d_i[14:12];
  assign rs1_d  = instr_d_i[19:15];
  assign rs2_d  = instr_d_i[24:20];
  assign rd_d   = instr_d_i[11:7];
  assign unused_instr_bits = ^{instr_d_i[31], instr_d_i[29:25]};

  ctrl_t                     ctrl_d, ctrl_p0;
  logic [IMMSRC_WIDTH-1:0]   imm_src_d;
  logic                      illegal_d, reads_rs2_d, alu_ok;
  logic [ALUCTRL_WIDTH-1:0]  alu_func;

  always_comb begin
    alu_ok   = 1'b1;
    alu_func = ALU_ADD;
    case (func3)
      3'b000:  alu_func = (opcode == OP_R && instr_d_i[30]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_func = ALU_AND;
      3'b110:  alu_func = ALU_OR;
      3'b100:  alu_func = ALU_XOR;
      3'b010:  alu_func = ALU_SLT;
      default: alu_ok   = 1'b0;
    endcase
  end

  // ID: decode; illegal encodings leave ctrl_d as an all-zero bubble
  always_comb begin
    ctrl_d      = '0;
    imm_src_d   = IMM_I;
    illegal_d   = 1'b0;
    reads_rs2_d = 1'b0;
    case (opcode)
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b01;
        ctrl_d.alu_src    = 1'b1;
      end
      OP_SW: begin
        reads_rs2_d      = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src_d        = IMM_S;
      end
      OP_R: begin
        reads_rs2_d = 1'b1;
        if (alu_ok) begin
          ctrl_d.reg_write   = 1'b1;
          ctrl_d.alu_control = alu_func;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_I: begin
        if (alu_ok) begin
          ctrl_d.reg_write   = 1'b1;
          ctrl_d.alu_control = alu_func;
          ctrl_d.alu_src     = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_BR: begin
        reads_rs2_d = 1'b1;
        if (func3[2:1] == 2'b00) begin
          ctrl_d.branch      = 1'b1;
          ctrl_d.branch_ne   = func3[0];
          ctrl_d.alu_control = ALU_SUB;
          imm_src_d          = IMM_B;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_JAL: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b10;
        imm_src_d         = IMM_J;
      end
      OP_JALR: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.jalr       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 2'b10;
        ctrl_d.alu_src    = 1'b1;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src_d        = IMM_U;
      end
      default: illegal_d = 1'b1;
    endcase
    if (!illegal_d) begin
      ctrl_d.rs1 = rs1_d;
      ctrl_d.rs2 = rs2_d;
      ctrl_d.rd  = ctrl_d.reg_write ? rd_d : '0;
    end
  end

  logic pc_src_e, lw_stall, flush_e;

  // EX: resolve redirect and load-use; a taken redirect suppresses the stall
  assign pc_src_e = ctrl_p0.jump | (ctrl_p0.branch & (zero_e_i ^ ctrl_p0.branch_ne));
  assign lw_stall = (ctrl_p0.result_src == 2'b01) && (ctrl_p0.rd != '0) &&
                    ((ctrl_p0.rd == rs1_d) || (reads_rs2_d && ctrl_p0.rd == rs2_d)) &&
                    !pc_src_e;
  assign flush_e  = lw_stall | pc_src_e;

  logic                      reg_write_p1, mem_write_p1, reg_write_p2;
  logic [1:0]                result_src_p1, result_src_p2;
  logic [REG_ADDR_WIDTH-1:0] rd_p1, rd_p2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_p0       <= '0;
      reg_write_p1  <= 1'b0;
      result_src_p1 <= 2'b00;
      mem_write_p1  <= 1'b0;
      rd_p1         <= '0;
      reg_write_p2  <= 1'b0;
      result_src_p2 <= 2'b00;
      rd_p2         <= '0;
    end else begin
      ctrl_p0       <= flush_e ? '0 : ctrl_d;
      reg_write_p1  <= ctrl_p0.reg_write;
      result_src_p1 <= ctrl_p0.result_src;
      mem_write_p1  <= ctrl_p0.mem_write;
      rd_p1         <= ctrl_p0.rd;
      reg_write_p2  <= reg_write_p1;
      result_src_p2 <= result_src_p1;
      rd_p2         <= rd_p1;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic                      wr_m,
    input logic [REG_ADDR_WIDTH-1:0] rd_m,
    input logic                      wr_w,
    input logic [REG_ADDR_WIDTH-1:0] rd_w
  );
    if (wr_m && rd_m != '0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != '0 && rd_w == rs) return 2'b01;
    else                                       return 2'b00;
  endfunction

  assign forward_a_e_o   = fwd_sel(ctrl_p0.rs1, reg_write_p1, rd_p1, reg_write_p2, rd_p2);
  assign forward_b_e_o   = fwd_sel(ctrl_p0.rs2, reg_write_p1, rd_p1, reg_write_p2, rd_p2);
  assign imm_src_d_o     = imm_src_d;
  assign illegal_d_o     = illegal_d;
  assign alu_control_e_o = ctrl_p0.alu_control;
  assign alu_src_e_o     = ctrl_p0.alu_src;
  assign pc_src_e_o      = pc_src_e;
  assign pc_src_reg_e_o  = ctrl_p0.jalr;
  assign mem_write_m_o   = mem_write_p1;
  assign result_src_w_o  = result_src_p2;
  assign reg_write_w_o   = reg_write_p2;
  assign rd_w_o          = rd_p2;
  assign stall_f_o       = lw_stall;
  assign stall_d_o       = lw_stall;
  assign flush_d_o       = pc_src_e;
  assign flush_e_o       = flush_e;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed scenarios with literal expectations plus
// random instruction streams checked every cycle against an instruction-level pipeline model.
module tb_pipe_control_unit;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [31:0] instr_d_i;
  logic        zero_e_i;
  logic [2:0]  imm_src_d_o;
  logic        illegal_d_o;
  logic [2:0]  alu_control_e_o;
  logic        alu_src_e_o, pc_src_e_o, pc_src_reg_e_o;
  logic [1:0]  forward_a_e_o, forward_b_e_o;
  logic        mem_write_m_o;
  logic [1:0]  result_src_w_o;
  logic        reg_write_w_o;
  logic [4:0]  rd_w_o;
  logic        stall_f_o, stall_d_o, flush_d_o, flush_e_o;

  always #5 clk = ~clk;

  pipe_control_unit dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .instr_d_i(instr_d_i), .zero_e_i(zero_e_i),
    .imm_src_d_o(imm_src_d_o), .illegal_d_o(illegal_d_o),
    .alu_control_e_o(alu_control_e_o), .alu_src_e_o(alu_src_e_o),
    .pc_src_e_o(pc_src_e_o), .pc_src_reg_e_o(pc_src_reg_e_o),
    .forward_a_e_o(forward_a_e_o), .forward_b_e_o(forward_b_e_o),
    .mem_write_m_o(mem_write_m_o), .result_src_w_o(result_src_w_o),
    .reg_write_w_o(reg_write_w_o), .rd_w_o(rd_w_o),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o),
    .flush_d_o(flush_d_o), .flush_e_o(flush_e_o)
  );

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] r1, input logic [11:0] imm);
    return {imm, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, 3'b010, 5'd4, 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, f3, 5'd8, 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    bit       rw;
    bit [1:0] res;
    bit       mw, br, bne, jmp, jalr;
    bit [2:0] alu;
    bit       asrc;
    bit [4:0] r1, r2, rd;
    bit [2:0] imm;
    bit       ill;
  } dec_t;

  function automatic dec_t bubble();
    dec_t d;
    d = '{default: 0};
    return d;
  endfunction

  function automatic bit reads_rs2(input logic [31:0] i);
    return i[6:0] == 7'b0110011 || i[6:0] == 7'b0100011 || i[6:0] == 7'b1100011;
  endfunction

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    int   alu;
    d = bubble();
    alu = -1;
    case (i[14:12])
      3'd0: alu = (i[6:0] == 7'b0110011 && i[30]) ? 1 : 0;
      3'd7: alu = 2;
      3'd6: alu = 3;
      3'd4: alu = 4;
      3'd2: alu = 5;
      default: alu = -1;
    endcase
    case (i[6:0])
      7'b0000011: begin d.rw = 1; d.res = 1; d.asrc = 1; end
      7'b0100011: begin d.mw = 1; d.asrc = 1; d.imm = 1; end
      7'b0110011: if (alu >= 0) begin d.rw = 1; d.alu = alu[2:0]; end else d.ill = 1;
      7'b0010011: if (alu >= 0) begin d.rw = 1; d.alu = alu[2:0]; d.asrc = 1; end else d.ill = 1;
      7'b1100011: if (i[14:12] <= 3'd1) begin
                    d.br = 1; d.bne = i[12]; d.alu = 1; d.imm = 2;
                  end else d.ill = 1;
      7'b1101111: begin d.jmp = 1; d.rw = 1; d.res = 2; d.imm = 3; end
      7'b1100111: begin d.jmp = 1; d.jalr = 1; d.rw = 1; d.res = 2; d.asrc = 1; end
      7'b0110111: begin d.rw = 1; d.asrc = 1; d.imm = 4; end
      default:    d.ill = 1;
    endcase
    if (!d.ill) begin
      d.r1 = i[19:15];
      d.r2 = i[24:20];
      d.rd = d.rw ? i[11:7] : 5'd0;
    end
    return d;
  endfunction

  // stage[0]=EX, stage[1]=MEM, stage[2]=WB; each holds the whole instruction record
  dec_t stage [3];

  function automatic bit m_pc_src();
    return stage[0].jmp || (stage[0].br && (zero_e_i != stage[0].bne));
  endfunction

  function automatic bit m_stall();
    logic [4:0] r1, r2;
    r1 = instr_d_i[19:15];
    r2 = instr_d_i[24:20];
    return stage[0].res == 2'd1 && stage[0].rd != 0 &&
           (stage[0].rd == r1 || (reads_rs2(instr_d_i) && stage[0].rd == r2)) && !m_pc_src();
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (stage[1].rw && stage[1].rd != 0 && stage[1].rd == r) return 2'b10;
    if (stage[2].rw && stage[2].rd != 0 && stage[2].rd == r) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < 3; k++) stage[k] <= bubble();
    end else begin
      stage[2] <= stage[1];
      stage[1] <= stage[0];
      stage[0] <= (m_stall() || m_pc_src()) ? bubble() : decode(instr_d_i);
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      dec_t d;
      d = decode(instr_d_i);
      chk("imm_src_d", imm_src_d_o, d.imm);
      chk("illegal_d", illegal_d_o, d.ill);
      chk("alu_control_e", alu_control_e_o, stage[0].alu);
      chk("alu_src_e", alu_src_e_o, stage[0].asrc);
      chk("pc_src_e", pc_src_e_o, m_pc_src());
      chk("pc_src_reg_e", pc_src_reg_e_o, stage[0].jalr);
      chk("forward_a_e", forward_a_e_o, m_fwd(stage[0].r1));
      chk("forward_b_e", forward_b_e_o, m_fwd(stage[0].r2));
      chk("mem_write_m", mem_write_m_o, stage[1].mw);
      chk("result_src_w", result_src_w_o, stage[2].res);
      chk("reg_write_w", reg_write_w_o, stage[2].rw);
      chk("rd_w", rd_w_o, stage[2].rd);
      chk("stall_f", stall_f_o, m_stall());
      chk("stall_d", stall_d_o, m_stall());
      chk("flush_d", flush_d_o, m_pc_src());
      chk("flush_e", flush_e_o, m_stall() || m_pc_src());
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] ins, input logic z);
    @(posedge clk);
    #1;
    instr_d_i = ins;
    zero_e_i  = z;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [31:0] raw;
    rd  = 5'($urandom_range(0, 3));
    r1  = 5'($urandom_range(0, 3));
    r2  = 5'($urandom_range(0, 3));
    raw = $urandom;
    case ($urandom_range(0, 11))
      0, 1:    return enc_r({1'b0, raw[0], 5'd0}, raw[3:1], rd, r1, r2);
      2:       return enc_i(7'b0010011, raw[3:1], rd, r1, raw[15:4]);
      3, 4, 5: return enc_i(7'b0000011, 3'b010, rd, r1, 12'd0);
      6:       return enc_s(r1, r2);
      7, 8:    return enc_b(3'($urandom_range(0, 2)), r1, r2);
      9:       return enc_u(7'b1101111, rd, raw[19:0]);
      10:      return enc_i(7'b1100111, 3'b000, rd, r1, 12'd0);
      default: return ($urandom_range(0, 1) == 0) ? enc_u(7'b0110111, rd, raw[19:0]) : raw;
    endcase
  endfunction

  initial begin
    logic [31:0] cur;
    bit hold, squash;
    rst_n_i   = 1'b0;
    instr_d_i = NOP;
    zero_e_i  = 1'b0;
    @(posedge clk);
    run_cmp = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_reg_write_w", reg_write_w_o, 0);
    chk("rst_pc_src_e", pc_src_e_o, 0);
    chk("rst_forward_a", forward_a_e_o, 0);
    chk("rst_stall_f", stall_f_o, 0);
    chk("rst_flush_e", flush_e_o, 0);
    @(posedge clk);
    #2 rst_n_i = 1'b1;

    // add x3,x1,x2 flows to WB; then an async reset drops it at once
    step(enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2), 1'b0);
    chk("add_stall_d", stall_d_o, 0);
    step(NOP, 1'b0);
    chk("add_alu_e", alu_control_e_o, 3'b000);
    chk("add_flush_e", flush_e_o, 0);
    step(NOP, 1'b0);
    step(NOP, 1'b0);
    chk("add_reg_write_w", reg_write_w_o, 1);
    chk("add_rd_w", rd_w_o, 3);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_reg_write_w", reg_write_w_o, 0);
    chk("midrst_rd_w", rd_w_o, 0);
    @(posedge clk);
    #2 rst_n_i = 1'b1;

    // load-use: lw x5,0(x0); add x6,x5,x1
    step(enc_i(7'b0000011, 3'b010, 5'd5, 5'd0, 12'd0), 1'b0);
    step(enc_r(7'h00, 3'b000, 5'd6, 5'd5, 5'd1), 1'b0);
    chk("lu_stall_f", stall_f_o, 1);
    chk("lu_stall_d", stall_d_o, 1);
    chk("lu_flush_e", flush_e_o, 1);
    step(enc_r(7'h00, 3'b000, 5'd6, 5'd5, 5'd1), 1'b0);
    chk("lu_stall_once", stall_d_o, 0);
    step(NOP, 1'b0);
    chk("lu_forward_a", forward_a_e_o, 2'b01);
    chk("lu_forward_b", forward_b_e_o, 2'b00);

    // beq/bne taken and not taken
    step(enc_b(3'b000, 5'd1, 5'd2), 1'b0);
    step(NOP, 1'b1);
    chk("beq_t_pc_src", pc_src_e_o, 1);
    chk("beq_t_flush_d", flush_d_o, 1);
    chk("beq_t_flush_e", flush_e_o, 1);
    step(enc_b(3'b000, 5'd1, 5'd2), 1'b0);
    step(NOP, 1'b0);
    chk("beq_n_pc_src", pc_src_e_o, 0);
    chk("beq_n_flush_d", flush_d_o, 0);
    chk("beq_n_flush_e", flush_e_o, 0);
    step(enc_b(3'b001, 5'd1, 5'd2), 1'b0);
    step(NOP, 1'b1);
    chk("bne_z1_pc_src", pc_src_e_o, 0);
    step(enc_b(3'b001, 5'd1, 5'd2), 1'b0);
    step(NOP, 1'b0);
    chk("bne_z0_pc_src", pc_src_e_o, 1);

    // forwarding from MEM, from WB, and never for x0
    step(enc_i(7'b0010011, 3'b000, 5'd7, 5'd0, 12'd1), 1'b0);
    step(enc_r(7'h20, 3'b000, 5'd8, 5'd7, 5'd7), 1'b0);
    step(NOP, 1'b0);
    chk("fwd_mem_a", forward_a_e_o, 2'b10);
    chk("fwd_mem_b", forward_b_e_o, 2'b10);
    chk("sub_alu_e", alu_control_e_o, 3'b001);
    step(enc_i(7'b0010011, 3'b000, 5'd7, 5'd0, 12'd1), 1'b0);
    step(NOP, 1'b0);
    step(enc_r(7'h20, 3'b000, 5'd8, 5'd7, 5'd7), 1'b0);
    step(NOP, 1'b0);
    chk("fwd_wb_a", forward_a_e_o, 2'b01);
    chk("fwd_wb_b", forward_b_e_o, 2'b01);
    step(enc_i(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd1), 1'b0);
    step(enc_r(7'h20, 3'b000, 5'd8, 5'd0, 5'd0), 1'b0);
    step(NOP, 1'b0);
    chk("fwd_x0_a", forward_a_e_o, 2'b00);
    chk("fwd_x0_b", forward_b_e_o, 2'b00);

    // jalr x1,0(x2)
    step(enc_i(7'b1100111, 3'b000, 5'd1, 5'd2, 12'd0), 1'b0);
    step(NOP, 1'b0);
    chk("jalr_pc_src", pc_src_e_o, 1);
    chk("jalr_pc_src_reg", pc_src_reg_e_o, 1);
    step(NOP, 1'b0);
    step(NOP, 1'b0);
    chk("jalr_result_src_w", result_src_w_o, 2'b10);
    chk("jalr_rd_w", rd_w_o, 1);

    // unsupported opcode
    step(32'h0000_01FF, 1'b0);
    chk("illegal_d", illegal_d_o, 1);
    step(NOP, 1'b0);
    step(NOP, 1'b0);
    step(NOP, 1'b0);
    chk("illegal_no_wb", reg_write_w_o, 0);

    // taken branch in EX with a consumer of x4 in ID: flush only
    step(enc_i(7'b0000011, 3'b010, 5'd4, 5'd0, 12'd0), 1'b0);
    step(enc_b(3'b000, 5'd1, 5'd2), 1'b0);
    step(enc_r(7'h00, 3'b000, 5'd5, 5'd4, 5'd4), 1'b1);
    chk("fw_stall_d", stall_d_o, 0);
    chk("fw_flush_d", flush_d_o, 1);
    chk("fw_flush_e", flush_e_o, 1);

    // random streams; the bench plays the datapath (hold on stall, nop after flush)
    cur = NOP;
    hold = 1'b0;
    squash = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) cur = squash ? NOP : rand_instr();
      step(cur, 1'($urandom_range(0, 1)));
      hold   = m_stall();
      squash = m_pc_src();
      if (n == 1500) begin
        rst_n_i = 1'b0;
        #1;
        chk("rand_rst_reg_write_w", reg_write_w_o, 0);
        @(posedge clk);
        #2 rst_n_i = 1'b1;
        hold = 1'b0;
        squash = 1'b0;
      end
    end

    step(NOP, 1'b0);
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
